cpu_trace_capture: RTL

Downstream observer for the 16-bit RISC CPU top-level wrapper. It samples the wrapper's 131-bit architectural snapshot (R0–R7, Zero, Carry and the dummy output). Whenever a sample differs from the previous one, it queues the sample in a small FIFO. It then streams each queued change as a variable-length packet of 16-bit words over a valid/ready interface to a logger or UART bridge.

---
 rtl/cpu_trace_capture_pkg.sv | 52 +++++
 rtl/cpu_trace_capture_if.sv | 10 +
 rtl/cpu_trace_capture_fifo.sv | 52 +++++
 rtl/cpu_trace_capture.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_trace_capture_pkg.sv
// Shared definitions for the CPU trace capture block: snapshot layout, header layout, FSM states, FIFO entry.
// The FIFO entry carries a 16-bit timestamp only when CPU_TRACE_TIMESTAMP_EN is defined.
package cpu_trace_pkg;

  localparam int SNAP_W    = 131;
  localparam int DUMMY_BIT = 130;
  localparam int Z_BIT     = 1;
  localparam int C_BIT     = 0;
  localparam int R_LSB [8] = '{114, 98, 82, 66, 50, 34, 18, 2};

  localparam int HDR_SEQ_LSB   = 13;
  localparam int HDR_LOST_BIT  = 12;
  localparam int HDR_DUMMY_BIT = 10;
  localparam int HDR_Z_BIT     = 9;
  localparam int HDR_C_BIT     = 8;

  typedef enum logic [1:0] {IDLE, HDR, TS, REG} state_t;

  typedef struct packed {
    logic [7:0]        mask;
    logic [SNAP_W-1:0] snap;
    logic              lost;
    logic [2:0]        seq;
`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [15:0]       ts;
`endif
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [2:0] low_idx(input logic [7:0] m);
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) low_idx = 3'(i);
    end
  endfunction

  function automatic logic [15:0] reg_word(input logic [SNAP_W-1:0] s, input logic [2:0] idx);
    reg_word = s[R_LSB[idx] +: 16];
  endfunction

  function automatic logic [15:0] hdr_word(input entry_t e);
    hdr_word = '0;
    hdr_word[HDR_SEQ_LSB +: 3] = e.seq;
    hdr_word[HDR_LOST_BIT]     = e.lost;
    hdr_word[HDR_DUMMY_BIT]    = e.snap[DUMMY_BIT];
    hdr_word[HDR_Z_BIT]        = e.snap[Z_BIT];
    hdr_word[HDR_C_BIT]        = e.snap[C_BIT];
    hdr_word[7:0]              = e.mask;
  endfunction

endpackage

// File: rtl/cpu_trace_capture_if.sv
// Valid/ready word stream from the trace capture block to a logger or UART bridge.
interface cpu_trace_capture_if;
  logic [15:0] trace_data;
  logic        trace_valid;
  logic        trace_ready;
  logic        trace_last;

  modport master (output trace_data, trace_valid, trace_last, input trace_ready);
  modport slave  (input trace_data, trace_valid, trace_last, output trace_ready);
endinterface

// File: rtl/cpu_trace_capture_fifo.sv
// trace_fifo: synchronous FIFO of DEPTH (power of two) entries; a push into a full FIFO is
// still accepted when a pop happens in the same cycle. Exposes the head and the entry behind it.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [W-1:0]             next,
  output logic                     accepted,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic          do_pop;

  assign do_pop   = pop && (level != '0);
  assign accepted = push && ((level < FULL_LEVEL) || do_pop);
  assign rd_next  = rd_ptr + AW'(1);
  assign head     = mem[rd_ptr];
  assign next     = mem[rd_next];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accepted) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_next;
      case ({accepted, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (accepted) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: queues every changed CPU snapshot and streams it as a variable-length packet.
// Define CPU_TRACE_TIMESTAMP_EN to add a free-running cycle timestamp word after each header.
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [130:0]           snap_in,
  input  logic                   snap_valid,
  cpu_trace_capture_if.master    trace,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [SNAP_W-1:0]  prev_snap, diff;
  logic [7:0]         chg_mask, wmask, wmask_n;
  logic               change, push_ok, pop, lost_pending, fire, last_n;
  logic [2:0]         seq;
  logic [15:0]        data_n;
  logic [ENTRY_W-1:0] head_raw, next_raw;
  entry_t             new_e, head_e, next_e;
  state_t             state, state_n;

  always_comb begin
    diff = snap_in ^ prev_snap;
    for (int i = 0; i < 8; i++) chg_mask[i] = |diff[R_LSB[i] +: 16];
  end

  assign change = snap_valid && (diff != '0);

`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 16'd1;
  end

  assign new_e = '{mask: chg_mask, snap: snap_in, lost: lost_pending, seq: seq, ts: ts_cnt};

  function automatic logic hdr_is_last(input logic [7:0] m);
    hdr_is_last = 1'b0 & (m == 8'd0);
  endfunction
`else
  assign new_e = '{mask: chg_mask, snap: snap_in, lost: lost_pending, seq: seq};

  function automatic logic hdr_is_last(input logic [7:0] m);
    hdr_is_last = (m == 8'd0);
  endfunction
`endif

  trace_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (change),
    .pop      (pop),
    .din      (new_e),
    .head     (head_raw),
    .next     (next_raw),
    .accepted (push_ok),
    .level    (fifo_level)
  );

  assign head_e = entry_t'(head_raw);
  assign next_e = entry_t'(next_raw);

  // The baseline follows every valid sample, so a dropped sample is not re-reported later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_snap    <= '0;
      seq          <= '0;
      lost_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (snap_valid) prev_snap <= snap_in;
      if (push_ok) begin
        seq          <= seq + 3'd1;
        lost_pending <= 1'b0;
      end else if (change) begin
        overflow     <= 1'b1;
        lost_pending <= 1'b1;
      end
    end
  end

  assign fire              = trace.trace_valid && trace.trace_ready;
  assign trace.trace_valid = (state != IDLE);

  // Computes the word to present after the next edge; wmask holds registers not yet sent.
  always_comb begin
    state_n = state;
    data_n  = trace.trace_data;
    last_n  = trace.trace_last;
    wmask_n = wmask;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          state_n = HDR;
          data_n  = hdr_word(head_e);
          wmask_n = head_e.mask;
          last_n  = hdr_is_last(head_e.mask);
        end
      end
      default: begin
        if (fire) begin
          if (trace.trace_last) begin
            pop = 1'b1;
            if (fifo_level > LW'(1)) begin
              state_n = HDR;
              data_n  = hdr_word(next_e);
              wmask_n = next_e.mask;
              last_n  = hdr_is_last(next_e.mask);
            end else begin
              state_n = IDLE;
              last_n  = 1'b0;
            end
          end
`ifdef CPU_TRACE_TIMESTAMP_EN
          else if (state == HDR) begin
            state_n = TS;
            data_n  = head_e.ts;
            last_n  = (wmask == 8'd0);
          end
`endif
          else begin
            state_n = REG;
            data_n  = reg_word(head_e.snap, low_idx(wmask));
            wmask_n = wmask & (wmask - 8'd1);
            last_n  = (wmask_n == 8'd0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wmask            <= '0;
      trace.trace_data <= '0;
      trace.trace_last <= 1'b0;
    end else begin
      state            <= state_n;
      wmask            <= wmask_n;
      trace.trace_data <= data_n;
      trace.trace_last <= last_n;
    end
  end

endmodule
